// File: rtl/warp_dispatcher_if.sv
// -----------------------------------------------------------------------------
// warp_dispatcher_if
//   Control/data bus between the warp dispatcher and the pending-warp
//   circular buffer. The dispatcher is the only agent that drives the
//   buffer controls.
//
//   Signals:
//     buf_push     master->slave  push launch_warp into the buffer tail
//     buf_wdata    master->slave  descriptor to push
//     buf_read     master->slave  present head on buf_rdata next cycle
//     buf_pop      master->slave  advance head at the rising edge
//     buf_rdata    slave->master  head descriptor (valid cycle after read)
//     buf_overflow slave->master  buffer saw a push while full
//
//   Modports: master (dispatcher side), slave (buffer side).
// -----------------------------------------------------------------------------
interface warp_dispatcher_if #(
    parameter int WARP_W = 8
);
    logic              buf_push;
    logic [WARP_W-1:0] buf_wdata;
    logic              buf_read;
    logic              buf_pop;
    logic [WARP_W-1:0] buf_rdata;
    logic              buf_overflow;

    modport master (
        output buf_push, buf_wdata, buf_read, buf_pop,
        input  buf_rdata, buf_overflow
    );

    modport slave (
        input  buf_push, buf_wdata, buf_read, buf_pop,
        output buf_rdata, buf_overflow
    );
endinterface : warp_dispatcher_if

// File: rtl/warp_dispatcher.sv
// -----------------------------------------------------------------------------
// warp_dispatcher
//   Sequencer and round-robin arbiter for the pending-warp circular buffer.
//   New warps from the launch path are pushed straight into the buffer
//   whenever there is room. Requesting cores are arbitrated round-robin; the
//   winner is served by a READ -> POP -> GRANT sequence that fetches the head
//   warp and presents it with a one-cycle one-hot grant. Occupancy is tracked
//   locally because the buffer only reports overflow.
//
//   Ports:
//     clk            rising-edge clock
//     rst            asynchronous active-low reset
//     launch_valid   new warp offered
//     launch_warp    descriptor offered
//     launch_ready   room available (count < DEPTH), low while in reset
//     core_req       per-core level request
//     core_grant     one-hot, one-cycle grant pulse
//     dispatch_warp  descriptor for the granted core (valid with core_grant)
//     buf_if         buffer control/data bus (master side)
//     occupancy      registered warp count
//     error          sticky: buffer overflow or count underflow
// -----------------------------------------------------------------------------
module warp_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 8,
    parameter int WARP_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         launch_valid,
    input  logic [WARP_W-1:0]            launch_warp,
    output logic                         launch_ready,

    input  logic [NUM_CORES-1:0]         core_req,
    output logic [NUM_CORES-1:0]         core_grant,
    output logic [WARP_W-1:0]            dispatch_warp,

    warp_dispatcher_if.master            buf_if,

    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         error
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(NUM_CORES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_POP   = 2'd2;
    localparam logic [1:0] S_GRANT = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [IDX_W-1:0]  winner_q,   winner_d;
    logic [WARP_W-1:0] dispatch_q, dispatch_d;
    logic              error_q,    error_d;

    logic              push;
    logic              pop;
    logic              underflow;
    logic [IDX_W-1:0]  arb_idx;

    // ------------------------------------------------------------------
    // Push path: independent of the dispatch sequence. Ready is held low
    // while reset is asserted so nothing is accepted during reset.
    // ------------------------------------------------------------------
    assign launch_ready     = rst & (count_q < CNT_W'(DEPTH));
    assign push             = launch_valid & launch_ready;
    assign pop              = (state_q == S_POP);

    assign buf_if.buf_push  = push;
    assign buf_if.buf_wdata = launch_warp;
    assign buf_if.buf_read  = (state_q == S_READ);
    assign buf_if.buf_pop   = pop;

    assign core_grant    = (state_q == S_GRANT) ? (NUM_CORES'(1) << winner_q) : '0;
    assign dispatch_warp = (state_q == S_GRANT) ? dispatch_q : '0;
    assign occupancy     = count_q;
    assign error         = error_q;

    // ------------------------------------------------------------------
    // Round-robin pick: scanning from the farthest offset down to offset 0
    // leaves the first requester at or after rr_ptr_q in arb_idx.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every variable assigned in always_comb gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        arb_idx = '0;
        cand    = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_CORES);
            if (core_req[cand]) begin
                arb_idx = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch sequence. IDLE only leaves when the registered count is
    // non-zero, so a warp being pushed this cycle is never the one read.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        rr_ptr_d   = rr_ptr_q;
        dispatch_d = dispatch_q;
        case (state_q)
            S_IDLE: begin
                if ((|core_req) && (count_q != '0)) begin
                    winner_d = arb_idx;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                state_d = S_POP;
            end
            S_POP: begin
                // Buffer presents the head the cycle after buf_read.
                dispatch_d = buf_if.buf_rdata;
                state_d    = S_GRANT;
            end
            S_GRANT: begin
                rr_ptr_d = (winner_q == IDX_W'(NUM_CORES - 1)) ? '0
                                                               : winner_q + IDX_W'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy: push and pop in the same cycle cancel out. A pop at zero
    // would mean the bookkeeping is broken; the count holds and the sticky
    // error flags it.
    // ------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        case ({push, pop})
            2'b10: count_d = count_q + CNT_W'(1);
            2'b01: begin
                if (count_q == '0) begin
                    underflow = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        error_d = error_q | buf_if.buf_overflow | underflow;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            dispatch_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            dispatch_q <= dispatch_d;
            error_q    <= error_d;
        end
    end

endmodule : warp_dispatcher
